stream_demux_pkt: RTL
=====================

// Module: stream_demux_pkt
// PURPOSE
//  Parametrised 1:NUM_OUT AXI-stream demultiplexer with packet-locked routing.
//  Routes each packet to one output, chosen by sel on the packet's first beat.
//  Both directions are registered through a 2-entry skid buffer, so there is no combinational path.
//  Packets addressed to a nonexistent port (sel >= NUM_OUT) are sunk and counted.
//  Sits between a stream source and NUM_OUT downstream stream sinks.
// PARAMETERS
//  DATA_WD  4  payload width in bits
//  NUM_OUT  4  number of output channels, 2..16
//  SEL_WD   2  sel width; must be >= clog2(NUM_OUT); values >= NUM_OUT are legal and mean drop
//  CNT_WD   8  width of the drop counter
// PORTS
//  clk       in   1                clock; all logic rises on posedge
//  rst_n     in   1                asynchronous, active-low reset
//  sel       in   SEL_WD           destination; sampled on the first beat of each packet only
//  a_valid   in   1                input beat valid
//  a_data    in   DATA_WD          input payload
//  a_last    in   1                input end-of-packet marker
//  a_ready   out  1                input ready; registered
//  m_valid   out  NUM_OUT          per-channel valid; one-hot or zero
//  m_data    out  DATA_WD          payload shared by all channels
//  m_last    out  1                end-of-packet marker shared by all channels
//  m_ready   in   NUM_OUT          per-channel ready
//  drop_cnt  out  CNT_WD           saturating count of dropped packets
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - m_valid=0, drop_cnt=0, in_pkt=0, both buffer entries empty.
//   - a_ready=0 while rst_n is low, and for the first clk edge after release; then a_ready=1.
//  Beat acceptance:
//   - A beat is accepted when a_fire = a_valid & a_ready.
//   - A beat leaves when m_fire = |(m_valid & m_ready).
//   - Each stored beat carries {data, last, dest}.
//  Destination lock:
//   - in_pkt is set on a_fire with a_last=0 and cleared on a_fire with a_last=1.
//   - dest = in_pkt ? lock_sel : sel. lock_sel captures sel on a_fire while in_pkt=0.
//   - sel changes in mid-packet are ignored.
//   - A single-beat packet (a_last=1 on its first beat) uses sel directly and leaves in_pkt=0.
//  Drop:
//   - If dest >= NUM_OUT, the beat is accepted normally but is not written to the buffer.
//   - On a_fire of the last beat of a dropped packet, drop_cnt increments; it saturates at all-ones.
//  Skid buffer (main entry M drives the outputs; skid entry S holds overflow):
//   - a_ready_next = ~S_valid_next. Accept-to-output latency is 1 cycle.
//   - Throughput is 1 beat/clk while the selected m_ready is held high.
//   - A kept beat goes into M if M is empty or M fires in the same cycle; otherwise it goes into S.
//   - When M fires and S is valid, S moves to M and S empties.
//   - Simultaneous a_fire and m_fire with S empty: the new beat replaces M with no bubble.
//   - Full (S valid): a_ready=0 on the next cycle. No beat is lost or reordered.
//  Outputs:
//   - m_valid[i] = M_valid & (M_dest==i). m_data and m_last come from M.
//   - m_data and m_last are don't-care when no m_valid bit is set.
//   - Once m_valid is high, M is stable until it fires (AXI rule).
//   - m_ready of unselected channels has no effect.
//  Ordering: strict input order across all channels; head-of-line blocking is intended.
//  Reset mid-packet: all state is cleared, the partial packet is discarded, and the next beat is a first beat.
// TESTING
//  1. Reset release, m_ready all 1, sel=2, 4-beat packet on back-to-back clks
//     -> m_valid=4'b0100 from the clk after the first accept; 4 beats in order; m_last on the 4th; a_ready never drops.
//  2. sel changes 2->0 at beat 2 of a 4-beat packet
//     -> all 4 beats go to ch2; the next packet goes to ch0.
//  3. m_ready[1]=0 while streaming to ch1
//     -> 2 beats are accepted and a_ready=0 on the 3rd clk.
//     -> m_ready[1]=1 drains both beats in order with no loss or duplication; a_ready returns to 1.
//  4. NUM_OUT=3, SEL_WD=2, sel=3, two 3-beat packets
//     -> m_valid stays 0, a_ready stays 1, drop_cnt=2.
//     -> CNT_WD=2 with 5 dropped packets gives drop_cnt=3 (saturated).
//  5. Single-beat packets alternating sel=0,1,0, m_ready all 1
//     -> one beat per clk to ch0, ch1, ch0; m_last=1 on each; in_pkt stays 0.
//  6. rst_n pulsed low with S full in mid-packet
//     -> m_valid=0 and a_ready=0 immediately.
//     -> After release, the first beat uses the current sel and drop_cnt=0.

Source files
------------

// File: rtl/stream_demux_pkt.sv
// 1:NUM_OUT AXI-stream demultiplexer with packet-locked routing.
// A 2-entry skid buffer registers both directions; packets to nonexistent ports are sunk and counted.
module stream_demux_pkt #(
    parameter int unsigned DATA_WD = 4,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned SEL_WD  = 2,
    parameter int unsigned CNT_WD  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_WD-1:0]  sel,
    input  logic               a_valid,
    input  logic [DATA_WD-1:0] a_data,
    input  logic               a_last,
    output logic               a_ready,
    output logic [NUM_OUT-1:0] m_valid,
    output logic [DATA_WD-1:0] m_data,
    output logic               m_last,
    input  logic [NUM_OUT-1:0] m_ready,
    output logic [CNT_WD-1:0]  drop_cnt
);

    localparam int unsigned DST_WD = SEL_WD + 1;

    typedef struct packed {
        logic [DATA_WD-1:0] data;
        logic               last;
    } beat_t;

    logic               in_pkt, in_pkt_n;
    logic [SEL_WD-1:0]  lock_sel, lock_sel_n;
    beat_t              m_q, m_n;
    beat_t              s_q, s_n;
    logic [SEL_WD-1:0]  s_dest, s_dest_n;
    logic               s_vld, s_vld_n;
    logic               a_ready_n;
    logic [NUM_OUT-1:0] m_valid_n;
    logic [CNT_WD-1:0]  drop_n;
    logic               a_fire, m_fire, keep;
    logic [SEL_WD-1:0]  dest;
    beat_t              in_beat;

    // One-hot channel decode of a destination known to be in range.
    function automatic logic [NUM_OUT-1:0] dec(input logic [SEL_WD-1:0] d);
        logic [NUM_OUT-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            v[i] = (d == SEL_WD'(i));
        end
        return v;
    endfunction

    // Next-state: destination lock, drop counting and skid-buffer movement.
    always_comb begin
        in_pkt_n   = in_pkt;
        lock_sel_n = lock_sel;
        m_n        = m_q;
        s_n        = s_q;
        s_dest_n   = s_dest;
        s_vld_n    = s_vld;
        m_valid_n  = m_valid;
        drop_n     = drop_cnt;

        a_fire  = a_valid & a_ready;
        m_fire  = |(m_valid & m_ready);
        dest    = in_pkt ? lock_sel : sel;
        keep    = a_fire && ({1'b0, dest} < DST_WD'(NUM_OUT));
        in_beat = '{data: a_data, last: a_last};

        if (a_fire) begin
            in_pkt_n = ~a_last;
            if (!in_pkt) begin
                lock_sel_n = sel;
            end
            if (!keep && a_last && (drop_cnt != '1)) begin
                drop_n = drop_cnt + CNT_WD'(1);
            end
        end

        // S is never valid while a beat is accepted, since a_ready tracks ~S.
        if (m_fire) begin
            if (s_vld) begin
                m_n       = s_q;
                m_valid_n = dec(s_dest);
                s_vld_n   = 1'b0;
            end else if (keep) begin
                m_n       = in_beat;
                m_valid_n = dec(dest);
            end else begin
                m_valid_n = '0;
            end
        end else if (keep) begin
            if (m_valid == '0) begin
                m_n       = in_beat;
                m_valid_n = dec(dest);
            end else begin
                s_n      = in_beat;
                s_dest_n = dest;
                s_vld_n  = 1'b1;
            end
        end

        a_ready_n = ~s_vld_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt   <= 1'b0;
            lock_sel <= '0;
            m_q      <= '0;
            s_q      <= '0;
            s_dest   <= '0;
            s_vld    <= 1'b0;
            m_valid  <= '0;
            a_ready  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            in_pkt   <= in_pkt_n;
            lock_sel <= lock_sel_n;
            m_q      <= m_n;
            s_q      <= s_n;
            s_dest   <= s_dest_n;
            s_vld    <= s_vld_n;
            m_valid  <= m_valid_n;
            a_ready  <= a_ready_n;
            drop_cnt <= drop_n;
        end
    end

    assign m_data = m_q.data;
    assign m_last = m_q.last;

endmodule
